// File: rtl/i2s_master_codec_if.sv
// I2S bus master: generates BCLK/LRCK from clk, serializes a held stereo play pair
// onto DACDAT and deserializes ADCDAT into stereo record pairs.
module i2s_master_codec_if #(
    parameter int BCLK_DIV  = 4,
    parameter int WORD_BITS = 16,
    parameter int SLOT_BITS = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    output logic                 aud_bclk,
    output logic                 aud_lrck,
    output logic                 aud_dacdat,
    input  logic                 aud_adcdat,
    input  logic [WORD_BITS-1:0] tx_left,
    input  logic [WORD_BITS-1:0] tx_right,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 underrun,
    output logic [WORD_BITS-1:0] rx_left,
    output logic [WORD_BITS-1:0] rx_right,
    output logic                 rx_valid
);
    localparam int FRAME_BITS = 2 * SLOT_BITS;
    localparam int DW         = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int BW         = $clog2(FRAME_BITS);
    localparam int PW         = 2 * WORD_BITS;

    localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_BITS - 1);
    localparam logic [BW-1:0] SLOT_LEN = BW'(SLOT_BITS);
    localparam logic [BW-1:0] WORD_LEN = BW'(WORD_BITS);
    localparam logic [BW-1:0] RX_LAST  = BW'(SLOT_BITS + WORD_BITS);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   div_cnt_q, div_cnt_d;
    logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
    logic            bclk_q, bclk_d;
    logic            lrck_q, lrck_d;
    logic            dacdat_q, dacdat_d;
    logic [PW-1:0]   tx_sh_q, tx_sh_d;
    logic [PW-1:0]   rx_sh_q, rx_sh_d;
    logic            rx_done_q, rx_done_d;
    logic            hold_full_q, hold_full_d;
    logic [PW-1:0]   hold_q, hold_d;
    logic            underrun_q, underrun_d;
    logic            rx_valid_q, rx_valid_d;
    logic [WORD_BITS-1:0] rx_left_q, rx_left_d;
    logic [WORD_BITS-1:0] rx_right_q, rx_right_d;
    logic            frame_start;
    logic [BW-1:0]   bit_next;

    function automatic logic [BW-1:0] slot_pos(input logic [BW-1:0] b);
        return (b >= SLOT_LEN) ? b - SLOT_LEN : b;
    endfunction

    function automatic logic in_word(input logic [BW-1:0] p);
        return (p != '0) && (p <= WORD_LEN);
    endfunction

    always_comb begin
        state_d     = state_q;
        div_cnt_d   = div_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        bclk_d      = bclk_q;
        lrck_d      = lrck_q;
        dacdat_d    = dacdat_q;
        tx_sh_d     = tx_sh_q;
        rx_sh_d     = rx_sh_q;
        rx_done_d   = 1'b0;
        hold_full_d = hold_full_q;
        hold_d      = hold_q;
        underrun_d  = 1'b0;
        rx_valid_d  = 1'b0;
        rx_left_d   = rx_left_q;
        rx_right_d  = rx_right_q;
        frame_start = 1'b0;
        bit_next    = '0;

        case (state_q)
            S_IDLE: begin
                div_cnt_d = '0;
                bit_cnt_d = '0;
                bclk_d    = 1'b0;
                lrck_d    = 1'b0;
                dacdat_d  = 1'b0;
                rx_sh_d   = '0;
                if (en) begin
                    state_d     = S_RUN;
                    frame_start = 1'b1;
                end
            end
            S_RUN: begin
                if (!en) begin
                    // Abort: in-flight frame and partial capture are dropped, hold survives.
                    state_d   = S_IDLE;
                    div_cnt_d = '0;
                    bit_cnt_d = '0;
                    bclk_d    = 1'b0;
                    lrck_d    = 1'b0;
                    dacdat_d  = 1'b0;
                    tx_sh_d   = '0;
                    rx_sh_d   = '0;
                end else begin
                    div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + 1'b1;
                    if (rx_done_q) begin
                        rx_valid_d = 1'b1;
                        rx_left_d  = rx_sh_q[PW-1:WORD_BITS];
                        rx_right_d = rx_sh_q[WORD_BITS-1:0];
                    end
                    if (div_cnt_q == DIV_LAST) begin
                        bclk_d = ~bclk_q;
                        if (bclk_q) begin
                            bit_next  = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + 1'b1;
                            bit_cnt_d = bit_next;
                            lrck_d    = (bit_next >= SLOT_LEN);
                            dacdat_d  = 1'b0;
                            if (in_word(slot_pos(bit_next))) begin
                                dacdat_d = tx_sh_q[PW-1];
                                tx_sh_d  = {tx_sh_q[PW-2:0], 1'b0};
                            end
                            frame_start = (bit_next == '0);
                        end else begin
                            if (in_word(slot_pos(bit_cnt_q))) begin
                                rx_sh_d = {rx_sh_q[PW-2:0], aud_adcdat};
                            end
                            rx_done_d = (bit_cnt_q == RX_LAST);
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (frame_start) begin
            if (hold_full_q) begin
                tx_sh_d     = hold_q;
                hold_full_d = 1'b0;
            end else begin
                tx_sh_d    = '0;
                underrun_d = 1'b1;
            end
        end

        // Handshake: a pair transfers on any edge where tx_valid && tx_ready; tx_ready is
        // the combinational inverse of hold_full_q, so a same-edge frame start never sees it.
        if (tx_valid && !hold_full_q) begin
            hold_d      = {tx_left, tx_right};
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            div_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            bclk_q      <= 1'b0;
            lrck_q      <= 1'b0;
            dacdat_q    <= 1'b0;
            tx_sh_q     <= '0;
            rx_sh_q     <= '0;
            rx_done_q   <= 1'b0;
            hold_full_q <= 1'b0;
            hold_q      <= '0;
            underrun_q  <= 1'b0;
            rx_valid_q  <= 1'b0;
            rx_left_q   <= '0;
            rx_right_q  <= '0;
        end else begin
            state_q     <= state_d;
            div_cnt_q   <= div_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            bclk_q      <= bclk_d;
            lrck_q      <= lrck_d;
            dacdat_q    <= dacdat_d;
            tx_sh_q     <= tx_sh_d;
            rx_sh_q     <= rx_sh_d;
            rx_done_q   <= rx_done_d;
            hold_full_q <= hold_full_d;
            hold_q      <= hold_d;
            underrun_q  <= underrun_d;
            rx_valid_q  <= rx_valid_d;
            rx_left_q   <= rx_left_d;
            rx_right_q  <= rx_right_d;
        end
    end

    assign aud_bclk   = bclk_q;
    assign aud_lrck   = lrck_q;
    assign aud_dacdat = dacdat_q;
    assign tx_ready   = ~hold_full_q;
    assign underrun   = underrun_q;
    assign rx_left    = rx_left_q;
    assign rx_right   = rx_right_q;
    assign rx_valid   = rx_valid_q;

endmodule

// File: tb/tb_i2s_master_codec_if.sv
// Bench for i2s_master_codec_if with DACDAT looped back to ADCDAT; outputs are
// predicted from elapsed clocks since enable and a queue of accepted pairs.
module tb_i2s_master_codec_if;
    localparam int BCLK_DIV   = 4;
    localparam int WORD_BITS  = 16;
    localparam int SLOT_BITS  = 32;
    localparam int BCLK_P     = 2 * BCLK_DIV;
    localparam int FRAME_BITS = 2 * SLOT_BITS;
    localparam int FRAME_CLK  = BCLK_P * FRAME_BITS;
    localparam int RX_PH      = BCLK_P * (SLOT_BITS + WORD_BITS) + BCLK_DIV + 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        aud_bclk, aud_lrck, aud_dacdat, aud_adcdat;
    logic [15:0] tx_left = '0;
    logic [15:0] tx_right = '0;
    logic        tx_valid = 1'b0;
    logic        tx_ready, underrun, rx_valid;
    logic [15:0] rx_left, rx_right;

    assign aud_adcdat = aud_dacdat;

    always #5 clk = ~clk;

    i2s_master_codec_if #(
        .BCLK_DIV (BCLK_DIV),
        .WORD_BITS(WORD_BITS),
        .SLOT_BITS(SLOT_BITS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .aud_bclk  (aud_bclk),
        .aud_lrck  (aud_lrck),
        .aud_dacdat(aud_dacdat),
        .aud_adcdat(aud_adcdat),
        .tx_left   (tx_left),
        .tx_right  (tx_right),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .underrun  (underrun),
        .rx_left   (rx_left),
        .rx_right  (rx_right),
        .rx_valid  (rx_valid)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: m_n = clocks since the enabling edge; exp_q holds the pair each
    // started frame will return through the loopback.
    bit          m_run = 1'b0;
    int          m_n = 0;
    bit          m_hold_full = 1'b0;
    logic [31:0] m_hold = '0;
    logic [31:0] m_word = '0;
    logic [31:0] m_rx = '0;
    bit          m_rxv = 1'b0;
    bit          m_unr = 1'b0;
    bit          m_hold_was, m_fs;
    logic [31:0] exp_q[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run = 1'b0; m_n = 0; m_hold_full = 1'b0; m_hold = '0;
            m_word = '0; m_rx = '0; m_rxv = 1'b0; m_unr = 1'b0;
            exp_q.delete();
        end else begin
            m_hold_was = m_hold_full;
            m_fs  = 1'b0;
            m_rxv = 1'b0;
            m_unr = 1'b0;
            if (!m_run) begin
                if (en) begin
                    m_run = 1'b1; m_n = 0; m_fs = 1'b1;
                end
            end else if (!en) begin
                m_run = 1'b0;
                if (exp_q.size() > 0) void'(exp_q.pop_back());
            end else begin
                m_n++;
                if (m_n % FRAME_CLK == 0) m_fs = 1'b1;
                if (m_n % FRAME_CLK == RX_PH && exp_q.size() > 0) begin
                    m_rxv = 1'b1;
                    m_rx  = exp_q.pop_front();
                end
            end
            if (m_fs) begin
                if (m_hold_was) begin
                    m_word = m_hold; m_hold_full = 1'b0;
                end else begin
                    m_word = '0; m_unr = 1'b1;
                end
                exp_q.push_back(m_word);
            end
            if (tx_valid && !m_hold_was) begin
                m_hold = {tx_left, tx_right};
                m_hold_full = 1'b1;
            end
        end
    end

    logic        e_bclk, e_lrck, e_dac;
    int          ck_bit, ck_p;
    logic [15:0] ck_w;

    always @(negedge clk) begin
        if (rst_n) begin
            e_bclk = 1'b0; e_lrck = 1'b0; e_dac = 1'b0;
            if (m_run) begin
                e_bclk = ((m_n / BCLK_DIV) % 2) == 1;
                ck_bit = (m_n / BCLK_P) % FRAME_BITS;
                ck_p   = ck_bit % SLOT_BITS;
                ck_w   = (ck_bit < SLOT_BITS) ? m_word[31:16] : m_word[15:0];
                e_lrck = ck_bit >= SLOT_BITS;
                e_dac  = (ck_p >= 1 && ck_p <= WORD_BITS) ? ck_w[WORD_BITS - ck_p] : 1'b0;
            end
            check_val("bclk", aud_bclk, e_bclk);
            check_val("lrck", aud_lrck, e_lrck);
            check_val("dacdat", aud_dacdat, e_dac);
            check_val("tx_ready", tx_ready, !m_hold_full);
            check_val("underrun", underrun, m_unr);
            check_val("rx_valid", rx_valid, m_rxv);
            check_val("rx_left", rx_left, m_rx[31:16]);
            check_val("rx_right", rx_right, m_rx[15:0]);
        end
    end

    task automatic push_pair(input logic [15:0] l, input logic [15:0] r);
        int guard;
        guard = 0;
        while (!tx_ready && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 2000) check_val("push_timeout", 32'd0, 32'd1);
        tx_left = l; tx_right = r; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic wait_rxv(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 1200 && !ok; i++) begin
            @(negedge clk);
            if (rx_valid) ok = 1'b1;
        end
    endtask

    task automatic measure_period(input bit use_lrck, output int period);
        int t1, t2;
        logic prev, cur;
        t1 = -1; t2 = -1; period = -1;
        prev = use_lrck ? aud_lrck : aud_bclk;
        for (int n = 0; n < 1500 && t2 < 0; n++) begin
            @(negedge clk);
            cur = use_lrck ? aud_lrck : aud_bclk;
            if (cur && !prev) begin
                if (t1 < 0) t1 = cyc; else t2 = cyc;
            end
            prev = cur;
        end
        if (t2 >= 0) period = t2 - t1;
    endtask

    task automatic stream(input int cycles, output int acc);
        logic tr_last;
        acc = 0;
        tr_last = tx_ready;
        tx_valid = 1'b1; tx_left = 16'($urandom); tx_right = 16'($urandom);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (tx_valid && tr_last) begin
                acc++;
                tx_left = 16'($urandom); tx_right = 16'($urandom);
            end
            tr_last = tx_ready;
        end
    endtask

    bit ok;
    int per, cnt_hi, cnt_hi_r, cnt_unr, cnt_rxv, acc;

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_bclk", aud_bclk, 0);
        check_val("rst_lrck", aud_lrck, 0);
        check_val("rst_dacdat", aud_dacdat, 0);
        check_val("rst_underrun", underrun, 0);
        check_val("rst_rx_valid", rx_valid, 0);
        check_val("rst_rx_pair", {rx_left, rx_right}, 0);
        check_val("rst_tx_ready", tx_ready, 1);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic loopback and clock periods
        push_pair(16'hA5C3, 16'h0F0F);
        en = 1'b1;
        wait_rxv(ok);
        check_val("t2_rxv_seen", ok, 1);
        check_val("t2_rx_pair", {rx_left, rx_right}, 32'hA5C3_0F0F);
        measure_period(1'b1, per);
        check_val("t2_lrck_period", per, 512);
        measure_period(1'b0, per);
        check_val("t2_bclk_period", per, 8);

        // Single-bit pattern then underrun frames
        en = 1'b0;
        @(negedge clk);
        push_pair(16'h8001, 16'h0000);
        en = 1'b1;
        cnt_hi = 0; cnt_hi_r = 0;
        for (int i = 0; i < FRAME_CLK; i++) begin
            @(negedge clk);
            if (aud_dacdat) cnt_hi++;
            if (aud_dacdat && aud_lrck) cnt_hi_r++;
        end
        check_val("t3_dac_high_clks", cnt_hi, 16);
        check_val("t3_dac_high_right", cnt_hi_r, 0);
        cnt_hi = 0; cnt_unr = 0;
        for (int i = 0; i < 3 * FRAME_CLK; i++) begin
            @(negedge clk);
            if (aud_dacdat) cnt_hi++;
            if (underrun) cnt_unr++;
        end
        check_val("t4_underruns", cnt_unr, 3);
        check_val("t4_dac_quiet", cnt_hi, 0);

        // Continuous offer: one accept per frame
        stream(600, acc);
        stream(4 * FRAME_CLK, acc);
        check_val("t5_accepts_4frames", acc, 4);
        tx_valid = 1'b0;

        // Abort at left-slot bit 8 with a pair held
        push_pair(16'h1234, 16'h5678);
        ok = 1'b0;
        for (int i = 0; i < 1200 && !ok; i++) begin
            if (m_run && (m_n % FRAME_CLK) >= 8 * BCLK_P && (m_n % FRAME_CLK) < 9 * BCLK_P) ok = 1'b1;
            else @(negedge clk);
        end
        check_val("t6_sync", ok, 1);
        check_val("t6_hold_full", tx_ready, 0);
        en = 1'b0;
        @(negedge clk);
        check_val("t6_pins_idle", {aud_bclk, aud_lrck, aud_dacdat}, 0);
        cnt_rxv = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (rx_valid) cnt_rxv++;
        end
        check_val("t6_no_rxv", cnt_rxv, 0);
        check_val("t6_hold_kept", tx_ready, 0);
        en = 1'b1;
        wait_rxv(ok);
        check_val("t6_rxv_seen", ok, 1);
        check_val("t6_rx_pair", {rx_left, rx_right}, 32'h1234_5678);

        // Asynchronous reset mid-frame, then restart from bit 0
        push_pair(16'($urandom), 16'($urandom));
        repeat (150) @(negedge clk);
        #2;
        rst_n = 1'b0; en = 1'b0; tx_valid = 1'b0;
        #1;
        check_val("t1_async_pins", {aud_bclk, aud_lrck, aud_dacdat}, 0);
        check_val("t1_async_pulses", {underrun, rx_valid}, 0);
        check_val("t1_async_rx", {rx_left, rx_right}, 0);
        check_val("t1_async_ready", tx_ready, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        check_val("t1_restart_underrun", underrun, 1);
        wait_rxv(ok);
        check_val("t1_restart_rxv", ok, 1);
        check_val("t1_restart_rx_zero", {rx_left, rx_right}, 0);

        // Random enable/offer mix
        for (int k = 0; k < 10; k++) begin
            en = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 1) == 1) stream($urandom_range(50, 700), acc);
            else repeat ($urandom_range(50, 700)) @(negedge clk);
            tx_valid = 1'b0;
        end
        en = 1'b0;
        repeat (10) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
